cg_axi5lite_regfile: RTL



---
 rtl/cg_axi5lite_pkg.sv | 34 +++
 rtl/cg_axi5lite_regfile.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cg_axi5lite_pkg.sv
// Shared AXI5-Lite helpers: protection width, address-to-index decode and
// byte-strobe merge used by the register file.
package cg_axi5lite_pkg;

    localparam int PROT_W = 3;

    // Word index of a byte address. idxw is the index width; the two byte-offset
    // bits are dropped and everything above the index is masked away.
    function automatic logic [31:0] addr_to_idx(
        input logic [31:0] addr,
        input int unsigned idxw
    );
        logic [31:0] mask;
        mask = (32'd1 << idxw) - 32'd1;
        return (addr >> 2) & mask;
    endfunction

    // Replace the bytes of old_val whose strobe bit is set with bytes of wdata.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [3:0]  wstrb
    );
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) begin
                merged[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/cg_axi5lite_regfile.sv
// AXI5-Lite subordinate exposing NUM_REGS read/write control registers.
// AW and W are captured independently and committed together; reads return
// the pre-commit value when they coincide with a write to the same register.
module cg_axi5lite_regfile
    import cg_axi5lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic [PROT_W-1:0]              AWPROT,
    input  logic                           WVALID,
    output logic                           WREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic [PROT_W-1:0]              ARPROT,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int IDXW   = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  aw_held_reg;
    logic                  w_held_reg;
    logic                  bvalid_reg;
    logic                  rvalid_reg;
    logic [ADDR_WIDTH-1:0] awaddr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_W-1:0]     wstrb_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [NUM_REGS-1:0]   wr_pulse_reg;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_in_range;
    logic [IDXW-1:0]       wr_idx;
    logic                  rd_in_range;
    logic [IDXW-1:0]       rd_idx;

    // Protection attributes carry no meaning for this block.
    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    // READY depends only on registered state and reset, never on any VALID.
    assign AWREADY = !aw_held_reg && !bvalid_reg && !ARESET;
    assign WREADY  = !w_held_reg  && !bvalid_reg && !ARESET;
    assign ARREADY = !rvalid_reg  && !ARESET;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID  && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // A held beat takes priority over the bus since the bus cannot handshake
    // while that channel is already holding.
    assign wr_addr = aw_held_reg ? awaddr_reg : AWADDR;
    assign wr_data = w_held_reg  ? wdata_reg  : WDATA;
    assign wr_strb = w_held_reg  ? wstrb_reg  : WSTRB;
    assign commit  = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);

    assign wr_in_range = wr_addr < ADDR_LIMIT;
    assign wr_idx      = IDXW'(addr_to_idx(32'(wr_addr), IDXW));
    assign rd_in_range = ARADDR < ADDR_LIMIT;
    assign rd_idx      = IDXW'(addr_to_idx(32'(ARADDR), IDXW));

    assign BVALID     = bvalid_reg;
    assign RVALID     = rvalid_reg;
    assign RDATA      = rdata_reg;
    assign wr_pulse_o = wr_pulse_reg;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_o
            assign regs_o[gi*DATA_WIDTH +: DATA_WIDTH] = regs[gi];
        end
    endgenerate

    // Write path: capture AW/W, commit when both are present, then respond on B.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            awaddr_reg   <= '0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            wr_pulse_reg <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_pulse_reg <= '0;
            if (bvalid_reg && BREADY) begin
                bvalid_reg <= 1'b0;
            end
            if (commit) begin
                bvalid_reg  <= 1'b1;
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                if (wr_in_range) begin
                    regs[wr_idx]         <= strb_merge(regs[wr_idx], wr_data, wr_strb);
                    wr_pulse_reg[wr_idx] <= 1'b1;
                end
            end else begin
                if (aw_hs) begin
                    aw_held_reg <= 1'b1;
                    awaddr_reg  <= AWADDR;
                end
                if (w_hs) begin
                    w_held_reg <= 1'b1;
                    wdata_reg  <= WDATA;
                    wstrb_reg  <= WSTRB;
                end
            end
        end
    end

    // Read path: sample the register (pre-commit value) on AR, hold until R handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_in_range ? regs[rd_idx] : '0;
        end else if (rvalid_reg && RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule
